// File: rtl/redirect_ctl_if.sv
// Decode/execute-side bus of the fetch-redirect controller (clk/clr stay plain ports).
// Defining REDIRECT_CTL_STATS_EN adds the br_cnt/mp_cnt statistics outputs.
interface redirect_ctl_if;
    logic        stall;
    logic        id_valid;
    logic        id_is_br;
    logic [63:0] id_pc;
    logic        jal_taken;
    logic [63:0] jal_addr;
    logic        pr_taken;
    logic [12:0] pr_offs;
    logic        ex_valid;
    logic        ex_taken;
    logic        trap;
    logic [63:0] trap_addr;
    logic        redir;
    logic [63:0] redir_addr;
    logic        flush;
    logic        mispredict;
    logic        bq_full;
`ifdef REDIRECT_CTL_STATS_EN
    logic [31:0] br_cnt;
    logic [31:0] mp_cnt;

    modport master (
        output stall, id_valid, id_is_br, id_pc, jal_taken, jal_addr,
               pr_taken, pr_offs, ex_valid, ex_taken, trap, trap_addr,
        input  redir, redir_addr, flush, mispredict, bq_full, br_cnt, mp_cnt
    );

    modport slave (
        input  stall, id_valid, id_is_br, id_pc, jal_taken, jal_addr,
               pr_taken, pr_offs, ex_valid, ex_taken, trap, trap_addr,
        output redir, redir_addr, flush, mispredict, bq_full, br_cnt, mp_cnt
    );
`else
    modport master (
        output stall, id_valid, id_is_br, id_pc, jal_taken, jal_addr,
               pr_taken, pr_offs, ex_valid, ex_taken, trap, trap_addr,
        input  redir, redir_addr, flush, mispredict, bq_full
    );

    modport slave (
        input  stall, id_valid, id_is_br, id_pc, jal_taken, jal_addr,
               pr_taken, pr_offs, ex_valid, ex_taken, trap, trap_addr,
        output redir, redir_addr, flush, mispredict, bq_full
    );
`endif
endinterface

// File: rtl/redirect_ctl.sv
// Fetch-redirect controller: arbitrates trap / mispredict / JAL / predicted-taken redirects
// and tracks in-flight branch predictions. REDIRECT_CTL_STATS_EN adds pop/mispredict counters.
module redirect_ctl #(
    parameter int DEPTH     = 4,
    parameter int FLUSH_CYC = 2
) (
    input logic           clk,
    input logic           clr,
    redirect_ctl_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int DW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(FLUSH_CYC - 1);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t          state, state_d;
    logic [DW-1:0]   drain_cnt, drain_cnt_d;

    logic            redir_q, redir_d;
    logic [63:0]     redir_addr_q, redir_addr_d;
    logic            flush_q, flush_d;
    logic            mis_q, mis_d;
    logic            full_q, full_d;

    logic            q_pred [DEPTH];
    logic [63:0]     q_addr [DEPTH];
    logic [PW-1:0]   wr_ptr, wr_ptr_d;
    logic [PW-1:0]   rd_ptr, rd_ptr_d;
    logic [CW-1:0]   count, count_d;

    logic [63:0]     offs_sext;
    logic [63:0]     br_target;
    logic [63:0]     seq_addr;
    logic            push_req;
    logic            pop_req;
    logic            head_mis;
    logic            jal_req;
    logic            take_req;
    logic            do_push;
    logic            do_pop;
    logic            clear_q;

    // Request qualification shared by the FSM and the queue bookkeeping.
    always_comb begin
        offs_sext = {{51{bus.pr_offs[12]}}, bus.pr_offs};
        br_target = bus.id_pc + offs_sext;
        seq_addr  = bus.id_pc + 64'd4;
        push_req  = (state == RUN) && bus.id_valid && bus.id_is_br && !bus.stall && !full_q;
        pop_req   = (state == RUN) && bus.ex_valid && (count != '0);
        head_mis  = pop_req && (bus.ex_taken != q_pred[rd_ptr]);
        jal_req   = (state == RUN) && bus.id_valid && bus.jal_taken && !bus.stall;
        take_req  = (push_req && bus.pr_taken) || jal_req;
    end

    always_comb begin
        state_d      = state;
        drain_cnt_d  = drain_cnt;
        redir_d      = 1'b0;
        redir_addr_d = redir_addr_q;
        flush_d      = 1'b0;
        mis_d        = 1'b0;
        clear_q      = 1'b0;
        do_push      = 1'b0;
        do_pop       = 1'b0;

        case (state)
            RUN: begin
                if (bus.trap) begin
                    redir_d      = 1'b1;
                    redir_addr_d = bus.trap_addr;
                    flush_d      = 1'b1;
                    clear_q      = 1'b1;
                    state_d      = DRAIN;
                    drain_cnt_d  = DRAIN_LOAD;
                end else if (head_mis) begin
                    redir_d      = 1'b1;
                    redir_addr_d = q_addr[rd_ptr];
                    mis_d        = 1'b1;
                    flush_d      = 1'b1;
                    clear_q      = 1'b1;
                    state_d      = DRAIN;
                    drain_cnt_d  = DRAIN_LOAD;
                end else begin
                    do_push = push_req;
                    do_pop  = pop_req;
                    if (take_req) begin
                        redir_d      = 1'b1;
                        flush_d      = 1'b1;
                        redir_addr_d = jal_req ? bus.jal_addr : br_target;
                    end
                end
            end
            DRAIN: begin
                // The entry cycle already showed flush, so the counter covers the remaining cycles.
                if (bus.trap) begin
                    redir_d      = 1'b1;
                    redir_addr_d = bus.trap_addr;
                    flush_d      = 1'b1;
                    clear_q      = 1'b1;
                    drain_cnt_d  = DRAIN_LOAD;
                end else if (drain_cnt == '0) begin
                    state_d = RUN;
                end else begin
                    flush_d     = 1'b1;
                    drain_cnt_d = drain_cnt - DW'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count;
        if (clear_q) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr + PW'(do_push);
            rd_ptr_d = rd_ptr + PW'(do_pop);
            count_d  = count + CW'(do_push) - CW'(do_pop);
        end
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= RUN;
            drain_cnt    <= '0;
            redir_q      <= 1'b0;
            redir_addr_q <= '0;
            flush_q      <= 1'b0;
            mis_q        <= 1'b0;
            full_q       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            state        <= state_d;
            drain_cnt    <= drain_cnt_d;
            redir_q      <= redir_d;
            redir_addr_q <= redir_addr_d;
            flush_q      <= flush_d;
            mis_q        <= mis_d;
            full_q       <= full_d;
            wr_ptr       <= wr_ptr_d;
            rd_ptr       <= rd_ptr_d;
            count        <= count_d;
        end
    end

    // Entry payload is the address to recover to if the prediction turns out wrong.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_pred[wr_ptr] <= bus.pr_taken;
            q_addr[wr_ptr] <= bus.pr_taken ? seq_addr : br_target;
        end
    end

    assign bus.redir      = redir_q;
    assign bus.redir_addr = redir_addr_q;
    assign bus.flush      = flush_q;
    assign bus.mispredict = mis_q;
    assign bus.bq_full    = full_q;

`ifdef REDIRECT_CTL_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mp_cnt_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (pop_req && (br_cnt_q != 32'hFFFF_FFFF)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mis_d && (mp_cnt_q != 32'hFFFF_FFFF)) begin
                mp_cnt_q <= mp_cnt_q + 32'd1;
            end
        end
    end

    assign bus.br_cnt = br_cnt_q;
    assign bus.mp_cnt = mp_cnt_q;
`endif
endmodule

// File: tb/tb_redirect_ctl.sv
// Scoreboard bench for redirect_ctl: expected redirects are queued by the stimulus
// and matched by an independent monitor whenever the DUT raises redir/mispredict.
module tb_redirect_ctl;
    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    redirect_ctl_if bus_if ();

    redirect_ctl #(
        .DEPTH     (4),
        .FLUSH_CYC (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    typedef struct {
        logic [63:0] addr;
        logic        mp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_redir(input logic [63:0] addr, input logic mp);
        exp_t e;
        e.addr = addr;
        e.mp   = mp;
        sb_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus_if.stall     = 1'b0;
        bus_if.id_valid  = 1'b0;
        bus_if.id_is_br  = 1'b0;
        bus_if.id_pc     = '0;
        bus_if.jal_taken = 1'b0;
        bus_if.jal_addr  = '0;
        bus_if.pr_taken  = 1'b0;
        bus_if.pr_offs   = '0;
        bus_if.ex_valid  = 1'b0;
        bus_if.ex_taken  = 1'b0;
        bus_if.trap      = 1'b0;
        bus_if.trap_addr = '0;
    endtask

    task automatic drive_branch(input logic [63:0] pc, input logic [12:0] offs, input logic taken);
        bus_if.id_valid = 1'b1;
        bus_if.id_is_br = 1'b1;
        bus_if.id_pc    = pc;
        bus_if.pr_offs  = offs;
        bus_if.pr_taken = taken;
    endtask

    task automatic drive_jal(input logic [63:0] addr);
        bus_if.id_valid  = 1'b1;
        bus_if.jal_taken = 1'b1;
        bus_if.jal_addr  = addr;
    endtask

    task automatic drive_resolve(input logic taken);
        bus_if.ex_valid = 1'b1;
        bus_if.ex_taken = taken;
    endtask

    task automatic drive_trap(input logic [63:0] addr);
        bus_if.trap      = 1'b1;
        bus_if.trap_addr = addr;
    endtask

    // One clock with the currently driven inputs, then back to idle at the sampling edge.
    task automatic applyStimulus();
        @(negedge clk);
        idle_inputs();
    endtask

    always @(negedge clk) begin
        if (!clr && (bus_if.redir === 1'b1 || bus_if.mispredict === 1'b1)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_redir: got redir=%0b addr=0x%0h mp=%0b, expected no redirect",
                         bus_if.redir, bus_if.redir_addr, bus_if.mispredict);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("sb_redir", 64'(bus_if.redir), 64'd1);
                checkOutput("sb_redir_addr", bus_if.redir_addr, e.addr);
                checkOutput("sb_mispredict", 64'(bus_if.mispredict), 64'(e.mp));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_redir", 64'(bus_if.redir), 64'd0);
        checkOutput("rst_redir_addr", bus_if.redir_addr, 64'd0);
        checkOutput("rst_flush", 64'(bus_if.flush), 64'd0);
        checkOutput("rst_mispredict", 64'(bus_if.mispredict), 64'd0);
        checkOutput("rst_bq_full", 64'(bus_if.bq_full), 64'd0);
        clr = 1'b0;
        applyStimulus();

        // Backward predicted-taken branch: 0x1000 - 16.
        drive_branch(64'h1000, 13'h1FF0, 1'b1);
        expect_redir(64'h0FF0, 1'b0);
        applyStimulus();
        checkOutput("t1_flush", 64'(bus_if.flush), 64'd1);
        checkOutput("t1_bq_full", 64'(bus_if.bq_full), 64'd0);
        applyStimulus();
        checkOutput("t1_flush_end", 64'(bus_if.flush), 64'd0);

        // Mispredict recovery to 0x1004; same-cycle push must be discarded.
        drive_resolve(1'b0);
        drive_branch(64'h3000, 13'h0010, 1'b0);
        expect_redir(64'h1004, 1'b1);
        applyStimulus();
        checkOutput("t2_flush0", 64'(bus_if.flush), 64'd1);
        drive_jal(64'h5550);
        drive_branch(64'h3100, 13'h0010, 1'b0);
        drive_resolve(1'b1);
        applyStimulus();
        checkOutput("t2_flush1", 64'(bus_if.flush), 64'd1);
        checkOutput("t2_mp_pulse", 64'(bus_if.mispredict), 64'd0);
        applyStimulus();
        checkOutput("t2_drain_done", 64'(bus_if.flush), 64'd0);
        drive_resolve(1'b1);
        applyStimulus();
        checkOutput("t2_queue_empty", 64'(bus_if.mispredict), 64'd0);

        // Forward not-taken branch that resolves taken.
        drive_branch(64'h2000, 13'h0040, 1'b0);
        applyStimulus();
        checkOutput("t3_no_redir", 64'(bus_if.redir), 64'd0);
        applyStimulus();
        drive_resolve(1'b1);
        expect_redir(64'h2040, 1'b1);
        applyStimulus();
        checkOutput("t3_flush0", 64'(bus_if.flush), 64'd1);
        applyStimulus();
        checkOutput("t3_flush1", 64'(bus_if.flush), 64'd1);
        applyStimulus();
        checkOutput("t3_flush_end", 64'(bus_if.flush), 64'd0);

        // Fill the queue, overflow attempt, then drain one.
        for (int i = 0; i < 4; i++) begin
            drive_branch(64'h100 * (i + 1), 13'h0010, 1'b0);
            applyStimulus();
            checkOutput("t4_fill_full", 64'(bus_if.bq_full), (i == 3) ? 64'd1 : 64'd0);
        end
        drive_branch(64'h500, 13'h0010, 1'b1);
        applyStimulus();
        checkOutput("t4_full_hold", 64'(bus_if.bq_full), 64'd1);
        checkOutput("t4_no_push_redir", 64'(bus_if.flush), 64'd0);
        drive_resolve(1'b0);
        applyStimulus();
        checkOutput("t4_pop_unfull", 64'(bus_if.bq_full), 64'd0);
        checkOutput("t4_correct_pop", 64'(bus_if.flush), 64'd0);
        drive_resolve(1'b1);
        expect_redir(64'h210, 1'b1);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("t4_flush_end", 64'(bus_if.flush), 64'd0);

        // Stall blocks a predicted-taken push.
        drive_branch(64'h700, 13'h0020, 1'b1);
        bus_if.stall = 1'b1;
        applyStimulus();
        checkOutput("t5_stall_blocks", 64'(bus_if.flush), 64'd0);

        // Trap wins over a mispredicting pop and a JAL; trap during DRAIN re-enters.
        drive_branch(64'h600, 13'h0020, 1'b1);
        expect_redir(64'h620, 1'b0);
        applyStimulus();
        applyStimulus();
        drive_trap(64'h8000_0000);
        drive_resolve(1'b0);
        drive_jal(64'h9000);
        expect_redir(64'h8000_0000, 1'b0);
        applyStimulus();
        checkOutput("t6_trap_flush", 64'(bus_if.flush), 64'd1);
        checkOutput("t6_trap_no_mp", 64'(bus_if.mispredict), 64'd0);
        drive_trap(64'hA000);
        expect_redir(64'hA000, 1'b0);
        applyStimulus();
        checkOutput("t6_retrap_flush0", 64'(bus_if.flush), 64'd1);
        applyStimulus();
        checkOutput("t6_retrap_flush1", 64'(bus_if.flush), 64'd1);
        applyStimulus();
        checkOutput("t6_retrap_end", 64'(bus_if.flush), 64'd0);
        drive_resolve(1'b0);
        applyStimulus();
        checkOutput("t6_queue_cleared", 64'(bus_if.redir), 64'd0);

        // JAL redirect.
        drive_jal(64'hDEAD_BEEF_0000_1230);
        expect_redir(64'hDEAD_BEEF_0000_1230, 1'b0);
        applyStimulus();
        checkOutput("t7_jal_flush", 64'(bus_if.flush), 64'd1);
        applyStimulus();
        checkOutput("t7_jal_flush_end", 64'(bus_if.flush), 64'd0);

        // Address arithmetic wraps modulo 2^64 for both target and recovery.
        drive_branch(64'hFFFF_FFFF_FFFF_FFFC, 13'h0008, 1'b1);
        expect_redir(64'h4, 1'b0);
        applyStimulus();
        applyStimulus();
        drive_resolve(1'b0);
        expect_redir(64'h0, 1'b1);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("t8_flush_end", 64'(bus_if.flush), 64'd0);

        // Reset in the middle of DRAIN.
        drive_trap(64'h4000);
        expect_redir(64'h4000, 1'b0);
        applyStimulus();
        #2;
        clr = 1'b1;
        #1;
        checkOutput("t9_clr_redir", 64'(bus_if.redir), 64'd0);
        checkOutput("t9_clr_addr", bus_if.redir_addr, 64'd0);
        checkOutput("t9_clr_flush", 64'(bus_if.flush), 64'd0);
        checkOutput("t9_clr_mp", 64'(bus_if.mispredict), 64'd0);
        checkOutput("t9_clr_full", 64'(bus_if.bq_full), 64'd0);
`ifdef REDIRECT_CTL_STATS_EN
        checkOutput("t9_clr_br_cnt", 64'(bus_if.br_cnt), 64'd0);
        checkOutput("t9_clr_mp_cnt", 64'(bus_if.mp_cnt), 64'd0);
`endif
        @(negedge clk);
        clr = 1'b0;
        drive_jal(64'h7000);
        expect_redir(64'h7000, 1'b0);
        applyStimulus();
        checkOutput("t9_run_after_clr", 64'(bus_if.flush), 64'd1);
        applyStimulus();
        applyStimulus();

        checkOutput("sb_all_seen", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
